// File: rtl/iiitb_cps_pkg.sv
// Shared definitions for the parking-gate arbiter.
//   state_e           : controller states; the encoding is the value driven on
//                       the indicator output.
//   DEFAULT_CAPACITY  : default lot capacity.
//   DEFAULT_PASS_CODE : default accepted entry password.
//   timer_width()     : width needed to hold the largest timer reload value.
package iiitb_cps_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_PASS  = 3'd1,
    S_WRONG      = 3'd2,
    S_ENTRY_OPEN = 3'd3,
    S_EXIT_OPEN  = 3'd4,
    S_LOCKED     = 3'd5
  } state_e;

  localparam int          DEFAULT_CAPACITY  = 8;
  localparam logic [3:0]  DEFAULT_PASS_CODE = 4'b1011;

  // The timer is reloaded with (duration - 1), so it only has to hold
  // max(duration) - 1.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/iiitb_cps_timer.sv
// Loadable down-counter shared by the gate window, password timeout and
// lockout.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, clears the count
//   i_load     : load i_load_val this edge (wins over counting)
//   i_load_val : reload value (duration - 1)
//   o_done     : count has reached zero (final cycle of the interval)
module iiitb_cps_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/iiitb_cps_gate_arbiter.sv
// Controller for the shared barrier gate of the parking lot.
//   clk             : clock, rising edge
//   reset           : synchronous active-high reset
//   sensor_entrance : car waiting at entrance (level)
//   sensor_exit     : car waiting at exit (level)
//   password        : entry password, meaningful only with pass_valid
//   pass_valid      : one-cycle strobe qualifying password
//   gate_open       : gate actuator drive
//   GREEN_LED       : gate open for entry or exit
//   RED_LED         : awaiting password, wrong password, or locked
//   indicator       : current state code (state_e encoding)
//   countcar        : current occupancy, 0..CAPACITY
//   full            : countcar == CAPACITY
//   lockout         : controller is in the lockout state
// Handshake: there is no ready; password is consumed on any cycle where
// pass_valid is high while the controller is in WAIT_PASS and is ignored in
// every other state.
// All outputs decode registered state only (Moore).
module iiitb_cps_gate_arbiter
  import iiitb_cps_pkg::*;
#(
  parameter int         CAPACITY     = DEFAULT_CAPACITY,
  parameter logic [3:0] PASS_CODE    = DEFAULT_PASS_CODE,
  parameter int         MAX_TRIES    = 3,
  parameter int         GATE_CYCLES  = 8,
  parameter int         PASS_TIMEOUT = 32,
  parameter int         LOCK_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [3:0] password,
  input  logic       pass_valid,
  output logic       gate_open,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [2:0] indicator,
  output logic [3:0] countcar,
  output logic       full,
  output logic       lockout
);

  localparam int         TW        = timer_width(GATE_CYCLES, PASS_TIMEOUT, LOCK_CYCLES);
  localparam logic [3:0] CAP       = 4'(CAPACITY);
  localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);

  state_e        r_state;
  state_e        w_next;
  logic [3:0]    r_count;
  logic [3:0]    w_count_next;
  logic [2:0]    r_tries;
  logic [2:0]    w_tries_next;
  logic          w_full;
  logic          w_done;
  logic          w_load;
  logic [TW-1:0] w_load_val;

  assign w_full = (r_count == CAP);

  // Next state, occupancy and retry counter.
  always_comb begin
    w_next       = r_state;
    w_count_next = r_count;
    w_tries_next = r_tries;
    case (r_state)
      S_IDLE: begin
        // Exit first: it frees a space.
        if (sensor_exit && (r_count != 4'd0)) begin
          w_next = S_EXIT_OPEN;
        end else if (sensor_entrance && !w_full) begin
          w_next = S_WAIT_PASS;
        end
      end
      S_WAIT_PASS: begin
        // A strobe in the timeout cycle still counts.
        if (pass_valid) begin
          if (password == PASS_CODE) begin
            w_next       = S_ENTRY_OPEN;
            w_tries_next = 3'd0;
          end else begin
            w_tries_next = r_tries + 3'd1;
            w_next       = ((r_tries + 3'd1) == TRIES_MAX) ? S_LOCKED : S_WRONG;
          end
        end else if (w_done) begin
          w_next       = S_IDLE;
          w_tries_next = 3'd0;
        end
      end
      S_WRONG: begin
        w_next = S_WAIT_PASS;
      end
      S_ENTRY_OPEN: begin
        if (w_done) begin
          w_next = S_IDLE;
          if (r_count != CAP) w_count_next = r_count + 4'd1;
        end
      end
      S_EXIT_OPEN: begin
        if (w_done) begin
          w_next = S_IDLE;
          if (r_count != 4'd0) w_count_next = r_count - 4'd1;
        end
      end
      S_LOCKED: begin
        if (w_done) begin
          w_next       = S_IDLE;
          w_tries_next = 3'd0;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The timer restarts on every state change with the length of the state
  // being entered; WRONG -> WAIT_PASS therefore gives a fresh timeout.
  always_comb begin
    w_load     = (w_next != r_state);
    w_load_val = '0;
    case (w_next)
      S_WAIT_PASS:              w_load_val = TW'(PASS_TIMEOUT - 1);
      S_ENTRY_OPEN, S_EXIT_OPEN: w_load_val = TW'(GATE_CYCLES - 1);
      S_LOCKED:                 w_load_val = TW'(LOCK_CYCLES - 1);
      default:                  w_load_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_tries <= 3'd0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_next;
      r_tries <= w_tries_next;
    end
  end

  iiitb_cps_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  assign indicator = r_state;
  assign gate_open = (r_state == S_ENTRY_OPEN) || (r_state == S_EXIT_OPEN);
  assign GREEN_LED = gate_open;
  assign RED_LED   = (r_state == S_WAIT_PASS) || (r_state == S_WRONG) ||
                     (r_state == S_LOCKED);
  assign lockout   = (r_state == S_LOCKED);
  assign countcar  = r_count;
  assign full      = w_full;

endmodule
